// File: rtl/mips_run_controller.sv
// Run/stop/dump controller beside the MIPS core: gates cpu_en for free-run,
// single-step and breakpoints, then streams the register file out on stop.
module mips_run_controller #(
  parameter int PC_W     = 32,
  parameter int DATA_W   = 32,
  parameter int NREG     = 32,
  parameter int STOP_PC  = 84,
  parameter int PC_LIMIT = 1024
) (
  input  logic              LOOP,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  input  logic              bp_en,
  input  logic [PC_W-1:0]   bp_addr,
  input  logic [PC_W-1:0]   pc,
  output logic              cpu_en,
  output logic              paused,
  output logic [4:0]        reg_rd_addr,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [4:0]        dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              done,
  output logic              limit_err,
  output logic [31:0]       instr_count
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RUN   = 3'd1;
  localparam logic [2:0] PAUSE = 3'd2;
  localparam logic [2:0] STEP  = 3'd3;
  localparam logic [2:0] DUMP  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic [4:0] LAST_IDX = 5'(NREG - 1);

  logic [2:0]  state;
  logic [2:0]  stateNext;
  logic [4:0]  idx;
  logic        bpMask;
  logic        limitErrQ;
  logic [31:0] instrCount;
  logic        limitHit;
  logic        stopHit;
  logic        bpHit;
  logic        bpLive;
  logic        cpuEn;
  logic        xfer;

  assign limitHit = (pc >= PC_W'(PC_LIMIT));
  assign stopHit  = (pc == PC_W'(STOP_PC)) || limitHit;
  assign bpHit    = bp_en && (pc == bp_addr);
  // bpMask lets the first RUN cycle after a resume execute the breakpoint PC.
  assign bpLive   = bpHit && !bpMask;
  assign xfer     = (state == DUMP) && dump_ready;

  always_comb begin
    cpuEn = 1'b0;
    case (state)
      RUN:     cpuEn = !stopHit && !bpLive;
      STEP:    cpuEn = 1'b1;
      default: cpuEn = 1'b0;
    endcase
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (start) stateNext = step_mode ? PAUSE : RUN;
      end
      RUN: begin
        if (stopHit)     stateNext = DUMP;
        else if (bpLive) stateNext = PAUSE;
      end
      PAUSE: begin
        if (stopHit)                  stateNext = DUMP;
        else if (step)                stateNext = STEP;
        else if (start && !step_mode) stateNext = RUN;
      end
      STEP:    stateNext = PAUSE;
      DUMP: begin
        if (xfer && (idx == LAST_IDX)) stateNext = DONE;
      end
      DONE:    stateNext = DONE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge LOOP or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      bpMask     <= 1'b0;
      limitErrQ  <= 1'b0;
      instrCount <= '0;
    end else begin
      state  <= stateNext;
      bpMask <= (state == PAUSE) && (stateNext == RUN);
      if (cpuEn && (instrCount != '1)) instrCount <= instrCount + 32'd1;
      if ((stateNext == DUMP) && (state != DUMP)) begin
        idx <= '0;
        if (limitHit) limitErrQ <= 1'b1;
      end else if (xfer) begin
        // idx returns to 0 after the last word so addresses read 0 in DONE.
        idx <= (idx == LAST_IDX) ? 5'd0 : idx + 5'd1;
      end
    end
  end

  assign cpu_en      = cpuEn;
  assign paused      = (state == PAUSE);
  assign dump_valid  = (state == DUMP);
  assign reg_rd_addr = idx;
  assign dump_addr   = idx;
  assign dump_data   = (state == DUMP) ? reg_rd_data : '0;
  assign done        = (state == DONE);
  assign limit_err   = limitErrQ;
  assign instr_count = instrCount;

endmodule

// File: doc/mips_run_controller.md
Name: mips_run_controller

Overview:
- Hardware run/stop/dump controller that sits beside the MIPS core and gates instruction execution.
- Lets a host start free-running execution, single-step, halt on a breakpoint, and stop at a terminal PC or PC limit.
- On stop, the block reads the register file out over a valid/ready stream, so end-of-run state can be captured without hierarchical access.

Parameters:
- PC_W, 32, program counter width.
- DATA_W, 32, register width.
- NREG, 32, number of registers dumped (addresses 0..NREG-1).
- STOP_PC, 84, terminal PC; reaching it ends the run normally.
- PC_LIMIT, 1024, PC at or above this value ends the run with an error.

Ports:
- LOOP  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins or resumes execution.
- step_mode  input  1  sampled with start: 1 means pause instead of run.
- step  input  1  one-cycle pulse; executes exactly one instruction while paused.
- bp_en  input  1  breakpoint enable.
- bp_addr  input  PC_W  breakpoint PC.
- pc  input  PC_W  current core PC.
- cpu_en  output  1  core advances one instruction on each rising edge while high.
- paused  output  1  high in PAUSE.
- reg_rd_addr  output  5  register-file asynchronous read address.
- reg_rd_data  input  DATA_W  register-file read data, combinational from reg_rd_addr.
- dump_valid  output  1  dump word available.
- dump_ready  input  1  consumer accepts the dump word.
- dump_addr  output  5  register index of dump_data.
- dump_data  output  DATA_W  register contents.
- done  output  1  dump finished (sticky).
- limit_err  output  1  run ended by PC_LIMIT (sticky).
- instr_count  output  32  instructions executed, i.e. cycles with cpu_en high.

Behaviour:
- Clock and reset: one clock, LOOP. Reset rst_n is asynchronous and active-low. Assertion at any time, including mid-RUN or mid-DUMP, forces IDLE and clears all outputs and counters to 0 (reg_rd_addr=0, dump_addr=0).
- States: IDLE, RUN, PAUSE, STEP, DUMP, DONE; state is registered.
- stop_hit = (pc==STOP_PC) or (pc>=PC_LIMIT). bp_hit = bp_en and (pc==bp_addr).
- IDLE:
  - start=1 and step_mode=0 -> RUN.
  - start=1 and step_mode=1 -> PAUSE.
  - step is ignored.
- RUN:
  - cpu_en = !stop_hit && !bp_hit (combinational), so the instruction at a stop or breakpoint PC is never executed.
  - stop_hit -> DUMP; limit_err is set if pc>=PC_LIMIT.
  - Otherwise bp_hit -> PAUSE.
  - stop_hit has priority over bp_hit.
- PAUSE:
  - cpu_en=0, paused=1.
  - stop_hit -> DUMP, with priority over all inputs.
  - Otherwise step=1 -> STEP.
  - Otherwise start=1 and step_mode=0 -> RUN. In this case the breakpoint is masked for the first RUN cycle so execution leaves the breakpoint PC.
  - start and step together in PAUSE: step wins.
- STEP: cpu_en=1 for exactly one cycle, then PAUSE unconditionally. Breakpoints are not checked in STEP.
- instr_count: increments by 1 on every edge where cpu_en=1; saturates at 0xFFFFFFFF.
- DUMP:
  - Internal index idx starts at 0 on entry.
  - reg_rd_addr = dump_addr = idx; dump_data = reg_rd_data (combinational pass-through); dump_valid=1.
  - On an edge with dump_valid && dump_ready, idx increments.
  - The transfer at idx=NREG-1 moves the block to DONE.
  - While dump_valid && !dump_ready, dump_addr and dump_data hold stable; the core is stopped, so the register file does not change.
  - start and step are ignored.
- DONE: dump_valid=0, done=1, cpu_en=0. The block stays in DONE until reset; start is ignored.
- Latency:
  - start to first cpu_en: 1 cycle.
  - stop_hit to first dump_valid: 1 cycle.
  - One register per cycle when dump_ready is held high, so NREG cycles for a full dump.

Test Plan:
- Reset, then start with step_mode=0 and a pc model that advances by 4 per cpu_en from 0 -> cpu_en high for 21 cycles, pc stops at 84, instr_count=21, dump emits addr 0..31 with the preloaded values, done=1, limit_err=0.
- bp_en=1, bp_addr=40, run -> pause at pc=40 with instr_count=10. Two step pulses -> pc=48, instr_count=12. start with step_mode=0 -> run to 84.
- dump_ready toggled 1,0,0,1 during DUMP -> dump_addr/dump_data held while ready=0; all 32 words delivered in order with none duplicated or skipped.
- pc jumps to 1024 during RUN -> cpu_en drops the same cycle, limit_err=1, dump completes, done=1.
- rst_n low mid-DUMP at idx=7 -> immediate IDLE, all outputs 0. A new start runs from scratch and the dump restarts at addr 0.
- bp_addr=84 with bp_en=1 -> run ends in DUMP, not PAUSE (stop_hit priority). A step pulse in IDLE and start pulses during DUMP/DONE have no effect.
